// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed 4-digit 7-segment driver.
//   - NUM_DIGITS  : digits on the board display
//   - SEG_BLANK   : all segments off (active-low)
//   - AN_OFF      : all digit enables off (active-low)
//   - AN_PATTERN  : active-low digit enable for each scan index
//   - ScanState   : driver state (BLANK until the first scan tick, then SCAN)
//   - glyph()     : hex nibble -> segment pattern, bit 6 = a ... bit 0 = g
//   - topDigit()  : index of the most significant nonzero nibble
// Ports: none (package).
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Element 0 is the rightmost digit; only one enable is pulled low at a time.
    localparam logic [NUM_DIGITS-1:0][3:0] AN_PATTERN = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } ScanState;

    // Segments are active-low, so a 0 bit lights that segment.
    function automatic logic [6:0] glyph(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'b0000001;
            4'h1:    pattern = 7'b1001111;
            4'h2:    pattern = 7'b0010010;
            4'h3:    pattern = 7'b0000110;
            4'h4:    pattern = 7'b1001100;
            4'h5:    pattern = 7'b0100100;
            4'h6:    pattern = 7'b0100000;
            4'h7:    pattern = 7'b0001111;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0000100;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b1100000;
            4'hC:    pattern = 7'b0110001;
            4'hD:    pattern = 7'b1000010;
            4'hE:    pattern = 7'b0110000;
            default: pattern = 7'b0111000;
        endcase
        return pattern;
    endfunction

    // An all-zero value reports digit 0 so that a lone "0" stays visible.
    function automatic logic [1:0] topDigit(input logic [15:0] value);
        logic [1:0] top;
        if (value[15:12] != 4'h0) begin
            top = 2'd3;
        end else if (value[11:8] != 4'h0) begin
            top = 2'd2;
        end else if (value[7:4] != 4'h0) begin
            top = 2'd1;
        end else begin
            top = 2'd0;
        end
        return top;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// -----------------------------------------------------------------------------
// seg7_prescaler
// Divides clk down to the digit scan rate: a counter runs 0..TICK_DIV-1 and
// tick is high for the single cycle where it sits at TICK_DIV-1.
// Parameters:
//   TICK_DIV : clk cycles per digit period (>= 1; 1 gives a tick every cycle)
//   CNT_W    : counter width, 2**CNT_W >= TICK_DIV
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low; clears the counter
//   tick  : one-cycle scan strobe
// -----------------------------------------------------------------------------
module seg7_prescaler #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running divider; wrapping on LAST_COUNT rather than on overflow
    // lets TICK_DIV be any value, not only a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST_COUNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST_COUNT);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Shows a 16-bit value as four hex digits on a multiplexed, active-low
// 7-segment display. One digit is lit per scan tick. The value is copied into a
// shadow register only at frame boundaries, so a frame never mixes old and new
// digits.
// Optional build macro:
//   LEADING_ZERO_BLANK_EN : blank digits above the highest nonzero nibble
//                           (digit 0 is always shown).
// Parameters:
//   TICK_DIV : clk cycles per digit period
//   CNT_W    : prescaler counter width
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-low reset
//   value_in   : value to display, digit0 = [3:0] ... digit3 = [15:12]
//   hold       : 1 = keep the current shadow at the frame wrap
//   dp_mask    : bit i lights the decimal point of digit i
//   an         : digit enables, active-low, at most one low
//   seg        : segments a..g on [6:0], active-low
//   dp         : decimal point, active-low
//   frame_done : one-cycle pulse when a full 4-digit frame completes
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        hold,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    logic        tick;

    ScanState    state;
    ScanState    stateNext;
    logic [1:0]  digitIdx;
    logic [1:0]  digitIdxNext;
    logic [15:0] shadow;
    logic [15:0] shadowNext;
    logic [3:0]  anNext;
    logic [6:0]  segNext;
    logic        dpNext;
    logic        frameDoneNext;

    seg7_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // All state and all display outputs are registered together, so the
    // outputs always describe the digit index held in digitIdx.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= BLANK;
            digitIdx   <= 2'd0;
            shadow     <= 16'h0000;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            digitIdx   <= digitIdxNext;
            shadow     <= shadowNext;
            an         <= anNext;
            seg        <= segNext;
            dp         <= dpNext;
            frame_done <= frameDoneNext;
        end
    end

    // Between ticks everything holds. On a tick the index advances and the
    // outputs are rebuilt from the next index and the next shadow value, so the
    // digit-0 glyph after a wrap already comes from the freshly loaded value.
    // The first tick out of BLANK always loads the shadow, ignoring hold, and
    // does not count as a completed frame.
    always_comb begin
        stateNext     = state;
        digitIdxNext  = digitIdx;
        shadowNext    = shadow;
        anNext        = an;
        segNext       = seg;
        dpNext        = dp;
        frameDoneNext = 1'b0;

        if (tick) begin
            case (state)
                BLANK: begin
                    stateNext    = SCAN;
                    digitIdxNext = 2'd0;
                    shadowNext   = value_in;
                end
                default: begin
                    digitIdxNext = digitIdx + 2'd1;
                    if (digitIdx == 2'd3) begin
                        frameDoneNext = 1'b1;
                        if (!hold) begin
                            shadowNext = value_in;
                        end
                    end
                end
            endcase

            anNext  = AN_PATTERN[digitIdxNext];
            segNext = glyph(shadowNext[{digitIdxNext, 2'b00} +: 4]);
            dpNext  = ~dp_mask[digitIdxNext];
`ifdef LEADING_ZERO_BLANK_EN
            if (digitIdxNext > topDigit(shadowNext)) begin
                segNext = SEG_BLANK;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver with TICK_DIV=4. The stimulus process
// drives inputs right after a chosen clock edge and queues the display state
// expected at each later edge where the digit enables change. A monitor,
// sampling on the falling edge, pops one entry per digit-enable change and
// compares edge number, an, seg, dp and frame_done.
// Build with LEADING_ZERO_BLANK_EN defined to expect blanked leading zeros.
// Ports: none.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        string      name;
    } DisplayEvent;

    localparam logic [6:0] G0   = 7'b0000001;
    localparam logic [6:0] G1   = 7'b1001111;
    localparam logic [6:0] G2   = 7'b0010010;
    localparam logic [6:0] G3   = 7'b0000110;
    localparam logic [6:0] G4   = 7'b1001100;
    localparam logic [6:0] G5   = 7'b0100100;
    localparam logic [6:0] GA   = 7'b0001000;
    localparam logic [6:0] GB   = 7'b1100000;
    localparam logic [6:0] GC   = 7'b0110001;
    localparam logic [6:0] GD   = 7'b1000010;
    localparam logic [6:0] GF   = 7'b0111000;
    localparam logic [6:0] GOFF = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] GZ   = GOFF;
`else
    localparam logic [6:0] GZ   = G0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        hold;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    DisplayEvent expQ[$];

    seg7_scan_driver #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .hold       (hold),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc reads k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic pushExpected(input int c, input logic [3:0] a, input logic [6:0] s,
                                input logic d, input logic f, input string n);
        DisplayEvent e;
        e.cyc  = c;
        e.an   = a;
        e.seg  = s;
        e.dp   = d;
        e.fd   = f;
        e.name = n;
        expQ.push_back(e);
    endtask

    // Drives all inputs 1ns after rising edge number afterEdge.
    task automatic applyStimulus(input int afterEdge, input logic rst, input logic [15:0] val,
                                 input logic hld, input logic [3:0] mask);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < afterEdge);
        reset    = rst;
        value_in = val;
        hold     = hld;
        dp_mask  = mask;
    endtask

    task automatic checkOutput(input DisplayEvent e);
        checks++;
        if (cyc !== e.cyc || an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
            errors++;
            $display("[TB] FAIL %s: got edge=%0d an=%b seg=%b dp=%b fd=%b, expected edge=%0d an=%b seg=%b dp=%b fd=%b",
                     e.name, cyc, an, seg, dp, frame_done, e.cyc, e.an, e.seg, e.dp, e.fd);
        end
    endtask

    // Monitor: every change of the digit enables is one display event. A
    // frame_done seen without an enable change is a stray or stretched pulse.
    initial begin
        logic [3:0] prevAn;
        prevAn = 'x;
        forever begin
            @(negedge clk);
            if (an !== prevAn) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEvent: got edge=%0d an=%b seg=%b, expected no change", cyc, an, seg);
                end else begin
                    checkOutput(expQ.pop_front());
                end
            end else if (frame_done !== 1'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL frameDoneStray: got frame_done=%b at edge %0d, expected 0", frame_done, cyc);
            end
            prevAn = an;
        end
    end

    initial begin
        reset    = 1'b0;
        value_in = 16'h0000;
        hold     = 1'b0;
        dp_mask  = 4'b0000;
        pushExpected(1, 4'b1111, GOFF, 1'b1, 1'b0, "resetState");

        // Release after three reset edges; the first tick lands on edge 7.
        applyStimulus(3, 1'b1, 16'h1234, 1'b0, 4'b0000);
        pushExpected(7,  4'b1110, G4, 1'b1, 1'b0, "firstTick");
        pushExpected(11, 4'b1101, G3, 1'b1, 1'b0, "scanIdx1");
        pushExpected(15, 4'b1011, G2, 1'b1, 1'b0, "scanIdx2");
        pushExpected(19, 4'b0111, G1, 1'b1, 1'b0, "scanIdx3");
        pushExpected(23, 4'b1110, G4, 1'b1, 1'b1, "firstWrap");
        pushExpected(27, 4'b1101, G3, 1'b1, 1'b0, "frame2Idx1");

        // New value mid-frame only shows after the wrap.
        applyStimulus(27, 1'b1, 16'hABCD, 1'b0, 4'b0000);
        pushExpected(31, 4'b1011, G2, 1'b1, 1'b0, "midFrameIdx2");
        pushExpected(35, 4'b0111, G1, 1'b1, 1'b0, "midFrameIdx3");
        pushExpected(39, 4'b1110, GD, 1'b1, 1'b1, "snapshotWrap");
        pushExpected(43, 4'b1101, GC, 1'b1, 1'b0, "snapshotIdx1");
        pushExpected(47, 4'b1011, GB, 1'b1, 1'b0, "snapshotIdx2");
        pushExpected(51, 4'b0111, GA, 1'b1, 1'b0, "snapshotIdx3");

        // Hold across the wrap keeps ABCD; frame_done still pulses.
        applyStimulus(51, 1'b1, 16'hFFFF, 1'b1, 4'b0000);
        pushExpected(55, 4'b1110, GD, 1'b1, 1'b1, "holdWrap");
        applyStimulus(56, 1'b1, 16'hFFFF, 1'b0, 4'b0000);
        pushExpected(59, 4'b1101, GC, 1'b1, 1'b0, "heldIdx1");
        pushExpected(63, 4'b1011, GB, 1'b1, 1'b0, "heldIdx2");
        pushExpected(67, 4'b0111, GA, 1'b1, 1'b0, "heldIdx3");
        pushExpected(71, 4'b1110, GF, 1'b1, 1'b1, "holdReleaseWrap");
        pushExpected(75, 4'b1101, GF, 1'b1, 1'b0, "newIdx1");

        // Decimal point on digit 2, then a one-cycle reset on the idx3 tick.
        applyStimulus(75, 1'b1, 16'hFFFF, 1'b0, 4'b0100);
        pushExpected(79, 4'b1011, GF, 1'b0, 1'b0, "dpIdx2");
        applyStimulus(82, 1'b0, 16'hFFFF, 1'b0, 4'b0100);
        pushExpected(83, 4'b1111, GOFF, 1'b1, 1'b0, "resetOnTick");
        applyStimulus(83, 1'b1, 16'hFFFF, 1'b0, 4'b0100);
        pushExpected(87, 4'b1110, GF, 1'b1, 1'b0, "blankDelayAgain");

        // Small values exercise leading-zero handling.
        applyStimulus(87, 1'b1, 16'h0005, 1'b0, 4'b0100);
        pushExpected(91,  4'b1101, GF, 1'b1, 1'b0, "oldFrameIdx1");
        pushExpected(95,  4'b1011, GF, 1'b0, 1'b0, "oldFrameIdx2");
        pushExpected(99,  4'b0111, GF, 1'b1, 1'b0, "oldFrameIdx3");
        pushExpected(103, 4'b1110, G5, 1'b1, 1'b1, "fiveDigit0");
        pushExpected(107, 4'b1101, GZ, 1'b1, 1'b0, "fiveDigit1");
        applyStimulus(107, 1'b1, 16'h0000, 1'b0, 4'b0100);
        pushExpected(111, 4'b1011, GZ, 1'b0, 1'b0, "fiveDigit2");
        pushExpected(115, 4'b0111, GZ, 1'b1, 1'b0, "fiveDigit3");
        pushExpected(119, 4'b1110, G0, 1'b1, 1'b1, "zeroDigit0");
        pushExpected(123, 4'b1101, GZ, 1'b1, 1'b0, "zeroDigit1");

        for (int i = 0; i < 60 && expQ.size() != 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending events, expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
